// File: rtl/irq_source_unit.sv
// Peripheral-side interrupt source: turns raw event lines into held requests,
// drops each one on its matching finish pulse and flags events lost while pending.
module irq_source_unit #(
    parameter int unsigned N_IRQ     = 32,
    parameter logic [31:0] EDGE_MASK = 32'hFFFF_FFFF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_IRQ-1:0] event_i,
    input  logic [N_IRQ-1:0] int_fin_i,
    input  logic [N_IRQ-1:0] clr_lost_i,
    output logic [N_IRQ-1:0] int_req_o,
    output logic [N_IRQ-1:0] lost_o,
    output logic [5:0]       pending_cnt_o
);

    typedef enum logic {StIdle, StPending} req_state_e;

    req_state_e       state_q [N_IRQ];
    req_state_e       state_d [N_IRQ];
    logic [N_IRQ-1:0] event_q;
    logic [N_IRQ-1:0] lost_q, lost_d;
    logic [N_IRQ-1:0] det;

    // event_q also loads during reset so a line high at release is not an edge
    always_ff @(posedge clk_i) begin
        event_q <= event_i;
        if (rst_i) begin
            lost_q <= '0;
            for (int unsigned i = 0; i < N_IRQ; i++) begin
                state_q[i] <= StIdle;
            end
        end else begin
            lost_q <= lost_d;
            for (int unsigned i = 0; i < N_IRQ; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    always_comb begin
        det    = '0;
        lost_d = lost_q;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            det[i]     = EDGE_MASK[i] ? (event_i[i] & ~event_q[i]) : event_i[i];
            state_d[i] = state_q[i];
            unique case (state_q[i])
                StIdle: begin
                    if (det[i]) begin
                        state_d[i] = StPending;
                    end
                end
                StPending: begin
                    if (int_fin_i[i]) begin
                        state_d[i] = det[i] ? StPending : StIdle;
                    end
                end
                default: state_d[i] = StIdle;
            endcase
            // Set wins over a same-cycle clear
            if (state_q[i] == StPending && !int_fin_i[i] && det[i] && EDGE_MASK[i]) begin
                lost_d[i] = 1'b1;
            end else if (clr_lost_i[i]) begin
                lost_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        int_req_o     = '0;
        pending_cnt_o = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            int_req_o[i]  = (state_q[i] == StPending);
            pending_cnt_o = pending_cnt_o + {5'd0, int_req_o[i]};
        end
        lost_o = lost_q;
    end

endmodule
